// File: rtl/v_sram_port_arbiter_if.sv
// Requester-side and SRAM-side buses of the vector SRAM port arbiter.
// The arbiter connects through the slave modport; clients and the SRAM macro connect through the master modport.
interface v_sram_port_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 9,
    parameter int DW   = 48
) ();
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ*DW-1:0] rsp_data;
    logic               sram_we;
    logic [AW-1:0]      sram_waddr1;
    logic [AW-1:0]      sram_waddr2;
    logic [DW-1:0]      sram_wdata1;
    logic [DW-1:0]      sram_wdata2;
    logic [AW-1:0]      sram_raddr1;
    logic [AW-1:0]      sram_raddr2;
    logic [DW-1:0]      sram_rdata1;
    logic [DW-1:0]      sram_rdata2;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, sram_rdata1, sram_rdata2,
        input  req_ready, rsp_valid, rsp_data, sram_we, sram_waddr1, sram_waddr2,
               sram_wdata1, sram_wdata2, sram_raddr1, sram_raddr2
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, sram_rdata1, sram_rdata2,
        output req_ready, rsp_valid, rsp_data, sram_we, sram_waddr1, sram_waddr2,
               sram_wdata1, sram_wdata2, sram_raddr1, sram_raddr2
    );
endinterface

// File: rtl/v_sram_port_arbiter.sv
// Round-robin arbiter sharing a 2R/2W vector SRAM among NREQ requesters.
// The SRAM read is registered inside the macro, so read tags travel two stages before capture.
module v_sram_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 9,
    parameter int DW   = 48
) (
    input  logic                        clock,
    input  logic                        reset,
    v_sram_port_arbiter_if.slave        bus,
    output logic [15:0]                 stall_cnt
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [AW-1:0]      addr_a  [NREQ];
    logic [DW-1:0]      wdata_a [NREQ];
    logic [NREQ-1:0]    grant;
    logic [1:0]         rd_cnt, wr_cnt;
    logic [IW-1:0]      rd_id1, rd_id2, wr_id1, wr_id2, idx, first_id;
    logic               any_grant;

    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               sram_we_q, sram_we_d;
    logic [AW-1:0]      waddr1_q, waddr1_d, waddr2_q, waddr2_d, raddr1_q, raddr1_d, raddr2_q, raddr2_d;
    logic [DW-1:0]      wdata1_q, wdata1_d, wdata2_q, wdata2_d;
    logic               iss_v1_q, iss_v1_d, iss_v2_q, iss_v2_d, stg_v1_q, stg_v1_d, stg_v2_q, stg_v2_d;
    logic [IW-1:0]      iss_id1_q, iss_id1_d, iss_id2_q, iss_id2_d, stg_id1_q, stg_id1_d, stg_id2_q, stg_id2_d;
    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [NREQ*DW-1:0] rsp_data_q, rsp_data_d;
    logic [15:0]        stall_q, stall_d;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) begin
            s = s - NREQ;
        end else begin
            s = s;
        end
        return IW'(s);
    endfunction

    // Unpack the flat request buses into per-requester arrays
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i]  = bus.req_addr[i*AW +: AW];
            wdata_a[i] = bus.req_wdata[i*DW +: DW];
        end
    end

    // Round-robin scan: up to two reads and two writes, never two writes to one address
    always_comb begin
        grant     = '0;
        rd_cnt    = 2'd0;
        wr_cnt    = 2'd0;
        rd_id1    = '0;
        rd_id2    = '0;
        wr_id1    = '0;
        wr_id2    = '0;
        idx       = '0;
        first_id  = '0;
        any_grant = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = wrap_idx(rr_ptr_q, k);
            if (!reset && bus.req_valid[idx]) begin
                if (bus.req_we[idx]) begin
                    if (wr_cnt == 2'd0) begin
                        grant[idx] = 1'b1;
                        wr_id1     = idx;
                        wr_cnt     = 2'd1;
                    end else if (wr_cnt == 2'd1 && addr_a[idx] != addr_a[wr_id1]) begin
                        grant[idx] = 1'b1;
                        wr_id2     = idx;
                        wr_cnt     = 2'd2;
                    end else begin
                        grant[idx] = 1'b0;
                    end
                end else begin
                    if (rd_cnt == 2'd0) begin
                        grant[idx] = 1'b1;
                        rd_id1     = idx;
                        rd_cnt     = 2'd1;
                    end else if (rd_cnt == 2'd1) begin
                        grant[idx] = 1'b1;
                        rd_id2     = idx;
                        rd_cnt     = 2'd2;
                    end else begin
                        grant[idx] = 1'b0;
                    end
                end
                if (grant[idx] && !any_grant) begin
                    any_grant = 1'b1;
                    first_id  = idx;
                end else begin
                    any_grant = any_grant;
                end
            end else begin
                grant[idx] = 1'b0;
            end
        end
    end

    // Issue stage: pointer, SRAM port registers and first read-tag stage
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        sram_we_d = (wr_cnt != 2'd0);
        waddr1_d  = waddr1_q;
        waddr2_d  = waddr2_q;
        wdata1_d  = wdata1_q;
        wdata2_d  = wdata2_q;
        raddr1_d  = raddr1_q;
        raddr2_d  = raddr2_q;
        iss_v1_d  = (rd_cnt != 2'd0);
        iss_v2_d  = (rd_cnt == 2'd2);
        iss_id1_d = rd_id1;
        iss_id2_d = rd_id2;
        if (any_grant) begin
            rr_ptr_d = (first_id == IW'(NREQ - 1)) ? '0 : first_id + IW'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        // A lone write drives both ports identically since the macro has one shared WE
        case (wr_cnt)
            2'd1: begin
                waddr1_d = addr_a[wr_id1];
                waddr2_d = addr_a[wr_id1];
                wdata1_d = wdata_a[wr_id1];
                wdata2_d = wdata_a[wr_id1];
            end
            2'd2: begin
                waddr1_d = addr_a[wr_id1];
                waddr2_d = addr_a[wr_id2];
                wdata1_d = wdata_a[wr_id1];
                wdata2_d = wdata_a[wr_id2];
            end
            default: begin
                waddr1_d = waddr1_q;
                waddr2_d = waddr2_q;
            end
        endcase
        case (rd_cnt)
            2'd1: raddr1_d = addr_a[rd_id1];
            2'd2: begin
                raddr1_d = addr_a[rd_id1];
                raddr2_d = addr_a[rd_id2];
            end
            default: raddr1_d = raddr1_q;
        endcase
    end

    // Tag stage aligned with SRAM read data, response capture and stall counter
    always_comb begin
        stg_v1_d    = iss_v1_q;
        stg_v2_d    = iss_v2_q;
        stg_id1_d   = iss_id1_q;
        stg_id2_d   = iss_id2_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (stg_v1_q) begin
            rsp_valid_d[stg_id1_q]                = 1'b1;
            rsp_data_d[int'(stg_id1_q)*DW +: DW] = bus.sram_rdata1;
        end else begin
            rsp_valid_d = rsp_valid_d;
        end
        if (stg_v2_q) begin
            rsp_valid_d[stg_id2_q]                = 1'b1;
            rsp_data_d[int'(stg_id2_q)*DW +: DW] = bus.sram_rdata2;
        end else begin
            rsp_valid_d = rsp_valid_d;
        end
        if (((bus.req_valid & ~grant) != '0) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            sram_we_q   <= 1'b0;
            waddr1_q    <= '0;
            waddr2_q    <= '0;
            wdata1_q    <= '0;
            wdata2_q    <= '0;
            raddr1_q    <= '0;
            raddr2_q    <= '0;
            iss_v1_q    <= 1'b0;
            iss_v2_q    <= 1'b0;
            iss_id1_q   <= '0;
            iss_id2_q   <= '0;
            stg_v1_q    <= 1'b0;
            stg_v2_q    <= 1'b0;
            stg_id1_q   <= '0;
            stg_id2_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            stall_q     <= 16'd0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            sram_we_q   <= sram_we_d;
            waddr1_q    <= waddr1_d;
            waddr2_q    <= waddr2_d;
            wdata1_q    <= wdata1_d;
            wdata2_q    <= wdata2_d;
            raddr1_q    <= raddr1_d;
            raddr2_q    <= raddr2_d;
            iss_v1_q    <= iss_v1_d;
            iss_v2_q    <= iss_v2_d;
            iss_id1_q   <= iss_id1_d;
            iss_id2_q   <= iss_id2_d;
            stg_v1_q    <= stg_v1_d;
            stg_v2_q    <= stg_v2_d;
            stg_id1_q   <= stg_id1_d;
            stg_id2_q   <= stg_id2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.req_ready   = grant;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.sram_we     = sram_we_q;
    assign bus.sram_waddr1 = waddr1_q;
    assign bus.sram_waddr2 = waddr2_q;
    assign bus.sram_wdata1 = wdata1_q;
    assign bus.sram_wdata2 = wdata2_q;
    assign bus.sram_raddr1 = raddr1_q;
    assign bus.sram_raddr2 = raddr2_q;
    assign stall_cnt       = stall_q;
endmodule
